alu_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that sits between the decoder and the top-level ALU / register-file SRAM.
- Accepts one decoded ALU operation per valid/ready handshake.
- Reads rs1 and rs2 through a single shared SRAM read port, drives the ALU enables and operands for exactly one cycle, then writes the result back to rd.
- Rejects illegal op encodings.

---
 rtl/alu_seq_ctrl_pkg.sv | 34 +++
 rtl/alu_seq_ctrl_if.sv | 56 +++++
 rtl/alu_seq_ctrl_op_legal_chk.sv | 27 ++
 rtl/alu_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
//   Shared definitions for the ALU sequencer slice:
//     - default widths for the op vector, register index and datapath
//     - bit positions of each operation inside the one-hot op vector
//     - the sequencer state enumeration
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    localparam int unsigned DEF_OP_W   = 9;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;

    // One-hot op vector bit positions.
    localparam int unsigned ADD = 0;
    localparam int unsigned SUB = 1;
    localparam int unsigned SLL = 2;
    localparam int unsigned SLT = 3;
    localparam int unsigned XOR = 4;
    localparam int unsigned SRA = 5;
    localparam int unsigned SRL = 6;
    localparam int unsigned OR  = 7;
    localparam int unsigned AND = 8;

    typedef enum logic [2:0] {
        IDLE,
        RS1,
        RS2,
        OPS,
        EXEC,
        WB
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl_if
//   Decoder-to-sequencer request channel (valid/ready handshake).
//   Ports:
//     req_valid      decoder has an op
//     req_ready      sequencer can accept an op
//     req_op         one-hot op enables
//     req_sign       signed (slt) vs unsigned (sltu) compare
//     req_imm_valid  second operand comes from req_imm
//     req_imm        immediate value
//     req_rs1/rs2/rd register indices
//   Modports: master = decoder side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface alu_seq_ctrl_if
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W   = DEF_OP_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic              req_sign;
    logic              req_imm_valid;
    logic [DATA_W-1:0] req_imm;
    logic [ADDR_W-1:0] req_rs1;
    logic [ADDR_W-1:0] req_rs2;
    logic [ADDR_W-1:0] req_rd;

    modport master (
        output req_valid,
        output req_op,
        output req_sign,
        output req_imm_valid,
        output req_imm,
        output req_rs1,
        output req_rs2,
        output req_rd,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_sign,
        input  req_imm_valid,
        input  req_imm,
        input  req_rs1,
        input  req_rs2,
        input  req_rd,
        output req_ready
    );

endinterface

// File: rtl/alu_seq_ctrl_op_legal_chk.sv
// ---------------------------------------------------------------------------
// op_legal_chk
//   Combinational legality check of an incoming op.
//   Ports:
//     op         one-hot op vector as presented by the decoder
//     imm_valid  second operand is an immediate
//     legal      op has exactly one bit set and is not sub-with-immediate
// ---------------------------------------------------------------------------
module op_legal_chk
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W = DEF_OP_W
) (
    input  logic [OP_W-1:0] op,
    input  logic            imm_valid,
    output logic            legal
);

    logic one_hot;

    always_comb begin
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        one_hot = (op != '0) && ((op & (op - OP_W'(1))) == '0);
        legal   = one_hot && !(op[SUB] && imm_valid);
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Multi-cycle sequencer between the decoder and the ALU / register file.
//   Accepts one op per handshake, reads rs1 then rs2 through the single
//   SRAM read port, presents operands to the ALU for one cycle, then writes
//   the result back to rd. Illegal op encodings are rejected with err.
//   Ports:
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     req              request channel (alu_seq_ctrl_if.slave)
//     rf_rd_en/addr    SRAM read strobe and address (data next cycle)
//     rf_rd_data       SRAM read data
//     alu_op_en        one-hot ALU enables, only during EXEC
//     alu_sign_valid   signed compare select, only during EXEC
//     alu_imm_valid    immediate select, only during EXEC
//     alu_imm          immediate, only during EXEC
//     alu_in1/alu_in2  ALU operands, only during EXEC
//     alu_out          combinational ALU result
//     rf_wr_en/addr/data  write-back port (x0 writes suppressed)
//     done             one-cycle pulse per completed op
//     err              one-cycle pulse per rejected op
//     busy             sequencer not idle
// ---------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W   = DEF_OP_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_ctrl_if.slave     req,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [OP_W-1:0]   alu_op_en,
    output logic              alu_sign_valid,
    output logic              alu_imm_valid,
    output logic [DATA_W-1:0] alu_imm,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              done,
    output logic              err,
    output logic              busy
);

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              op_legal;
    logic              err_q;

    logic [OP_W-1:0]   op_q;
    logic              sign_q;
    logic              imm_valid_q;
    logic [DATA_W-1:0] imm_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [DATA_W-1:0] result_q;

    // Ready depends only on state, so accept never loops through the FSM logic.
    assign req.req_ready = (state == IDLE);
    assign accept        = req.req_valid && (state == IDLE);
    assign busy          = (state != IDLE);
    assign err           = err_q;

    op_legal_chk #(
        .OP_W (OP_W)
    ) u_op_legal_chk (
        .op        (req.req_op),
        .imm_valid (req.req_imm_valid),
        .legal     (op_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q       <= 1'b0;
            op_q        <= '0;
            sign_q      <= 1'b0;
            imm_valid_q <= 1'b0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
        end else begin
            err_q <= accept && !op_legal;

            if (accept) begin
                op_q        <= req.req_op;
                sign_q      <= req.req_sign;
                imm_valid_q <= req.req_imm_valid;
                imm_q       <= req.req_imm;
                rs1_q       <= req.req_rs1;
                rs2_q       <= req.req_rs2;
                rd_q        <= req.req_rd;
            end

            case (state)
                RS2: begin
                    // x0 always reads as zero regardless of SRAM contents.
                    op1_q <= (rs1_q == '0) ? '0 : rf_rd_data;
                    if (imm_valid_q) begin
                        op2_q <= '0;
                    end
                end
                OPS: begin
                    op2_q <= (rs2_q == '0) ? '0 : rf_rd_data;
                end
                EXEC: begin
                    result_q <= alu_out;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        rf_rd_en       = 1'b0;
        rf_rd_addr     = '0;
        alu_op_en      = '0;
        alu_sign_valid = 1'b0;
        alu_imm_valid  = 1'b0;
        alu_imm        = '0;
        alu_in1        = '0;
        alu_in2        = '0;
        rf_wr_en       = 1'b0;
        rf_wr_addr     = '0;
        rf_wr_data     = '0;
        done           = 1'b0;

        case (state)
            IDLE: begin
                // Illegal ops stay here; err is raised from the registered flag.
                if (req.req_valid && op_legal) begin
                    state_nxt = RS1;
                end
            end
            RS1: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = rs1_q;
                state_nxt  = RS2;
            end
            RS2: begin
                // The rs2 read overlaps the cycle in which rs1 data is captured.
                if (!imm_valid_q) begin
                    rf_rd_en   = 1'b1;
                    rf_rd_addr = rs2_q;
                    state_nxt  = OPS;
                end else begin
                    state_nxt  = EXEC;
                end
            end
            OPS: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                alu_op_en      = op_q;
                alu_sign_valid = sign_q;
                alu_imm_valid  = imm_valid_q;
                alu_imm        = imm_q;
                alu_in1        = op1_q;
                alu_in2        = op2_q;
                state_nxt      = WB;
            end
            WB: begin
                rf_wr_en   = (rd_q != '0);
                rf_wr_addr = rd_q;
                rf_wr_data = result_q;
                done       = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//   Scoreboard bench for alu_seq_ctrl. The driver computes each op's result
//   from a reference register array and pushes the expected event; a monitor
//   pops and compares whenever done/err is seen, and also checks the EXEC
//   cycle contents and the always-true control rules every cycle.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rf_rd_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [8:0]  alu_op_en;
    logic        alu_sign_valid;
    logic        alu_imm_valid;
    logic [31:0] alu_imm;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        done;
    logic        err;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    alu_seq_ctrl_if #(.OP_W(9), .ADDR_W(5), .DATA_W(32)) rif ();

    alu_seq_ctrl #(.OP_W(9), .ADDR_W(5), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (rif),
        .rf_rd_en       (rf_rd_en),
        .rf_rd_addr     (rf_rd_addr),
        .rf_rd_data     (rf_rd_data),
        .alu_op_en      (alu_op_en),
        .alu_sign_valid (alu_sign_valid),
        .alu_imm_valid  (alu_imm_valid),
        .alu_imm        (alu_imm),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .alu_out        (alu_out),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data),
        .done           (done),
        .err            (err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain-arithmetic behaviour of each one-hot op.
    function automatic logic [31:0] alu_f(input logic [8:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic sgn);
        case (op)
            9'h001: return a + b;
            9'h002: return a - b;
            9'h004: return a << b[4:0];
            9'h008: return sgn ? 32'($signed(a) < $signed(b)) : 32'(a < b);
            9'h010: return a ^ b;
            9'h020: return 32'($signed(a) >>> b[4:0]);
            9'h040: return a >> b[4:0];
            9'h080: return a | b;
            9'h100: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Environment ALU driven by the DUT's EXEC outputs.
    assign alu_out = alu_f(alu_op_en, alu_in1, alu_imm_valid ? alu_imm : alu_in2, alu_sign_valid);

    // Register-file SRAM: one-cycle read latency, junk when not reading.
    logic [31:0] mem [32];
    logic        bk_we;
    logic [4:0]  bk_addr;
    logic [31:0] bk_data;
    always @(posedge clk) begin
        if (bk_we) mem[bk_addr] <= bk_data;
        else if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
        rf_rd_data <= rf_rd_en ? mem[rf_rd_addr] : $urandom();
    end

    logic [31:0] ref_rf [32];

    typedef struct {
        bit          is_err;
        logic [8:0]  op;
        logic        sgn;
        logic        immv;
        logic [31:0] imm;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic [31:0] data;
        int          exec_cyc;
        int          done_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, expv);
        end
    endtask

    // Monitor: sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("rd_wr_exclusive", 32'(rf_rd_en && rf_wr_en), 32'd0);
            chk("rd_addr_idle", rf_rd_en ? 32'd0 : 32'(rf_rd_addr), 32'd0);
            chk("busy_vs_ready", 32'(busy), 32'(!rif.req_ready));
            chk("wr_implies_done", 32'(rf_wr_en && !done), 32'd0);
            if (alu_op_en != 9'd0) begin
                if (exp_q.size() == 0) begin
                    chk("exec_unexpected", 32'(alu_op_en), 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("exec_op", 32'(alu_op_en), 32'(e.op));
                    chk("exec_cycle", 32'(cyc), 32'(e.exec_cyc));
                    chk("exec_in1", alu_in1, e.in1);
                    chk("exec_in2", alu_in2, e.in2);
                    chk("exec_imm", alu_imm, e.imm);
                    chk("exec_ctl", 32'({alu_sign_valid, alu_imm_valid}), 32'({e.sgn, e.immv}));
                end
            end else begin
                chk("alu_idle_data", alu_in1 | alu_in2 | alu_imm, 32'd0);
                chk("alu_idle_ctl", 32'({alu_sign_valid, alu_imm_valid}), 32'd0);
            end
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    chk("event_unexpected", 32'({done, err}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'({done, err}), e.is_err ? 32'd1 : 32'd2);
                    chk("event_cycle", 32'(cyc), 32'(e.done_cyc));
                    if (!e.is_err) begin
                        chk("wb_en", 32'(rf_wr_en), 32'(e.rd != 5'd0));
                        if (e.rd != 5'd0) begin
                            chk("wb_addr", 32'(rf_wr_addr), 32'(e.rd));
                            chk("wb_data", rf_wr_data, e.data);
                        end
                    end
                end
            end
        end
    end

    // Called and returns on a falling edge.
    task automatic set_reg(input logic [4:0] i, input logic [31:0] v);
        bk_we   = 1'b1;
        bk_addr = i;
        bk_data = v;
        ref_rf[i] = (i == 5'd0) ? 32'd0 : v;
        @(posedge clk);
        #1 bk_we = 1'b0;
        @(negedge clk);
    endtask

    // Called on a falling edge; handshake occurs on the following rising edge.
    task automatic issue(input logic [8:0] op, input logic sgn, input logic immv,
                         input logic [31:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, output int rdy_cyc);
        exp_t e;
        int   t;
        bit   legal;
        t = cyc;
        chk("ready_at_issue", 32'(rif.req_ready), 32'd1);
        rif.req_valid     = 1'b1;
        rif.req_op        = op;
        rif.req_sign      = sgn;
        rif.req_imm_valid = immv;
        rif.req_imm       = imm;
        rif.req_rs1       = rs1;
        rif.req_rs2       = rs2;
        rif.req_rd        = rd;
        legal = ($countones(op) == 1) && !(op[1] && immv);
        e.is_err = !legal;
        e.op     = op;
        e.sgn    = sgn;
        e.immv   = immv;
        e.imm    = imm;
        e.rd     = rd;
        e.in1    = ref_rf[rs1];
        e.in2    = immv ? 32'd0 : ref_rf[rs2];
        e.data   = alu_f(op, e.in1, immv ? imm : e.in2, sgn);
        if (legal) begin
            e.exec_cyc = t + (immv ? 3 : 4);
            e.done_cyc = e.exec_cyc + 1;
            rdy_cyc    = e.done_cyc + 1;
            if (rd != 5'd0) ref_rf[rd] = e.data;
        end else begin
            e.exec_cyc = -1;
            e.done_cyc = t + 1;
            rdy_cyc    = t + 1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        rif.req_op    = 9'($urandom());
        rif.req_imm   = $urandom();
        rif.req_rs1   = 5'($urandom());
        rif.req_rs2   = 5'($urandom());
        rif.req_rd    = 5'($urandom());
    endtask

    // Ends on the falling edge where req_ready is first seen high.
    task automatic wait_ready(input int exp_cyc);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!rif.req_ready && g < 40);
        if (!rif.req_ready) chk("ready_timeout", 32'd0, 32'd1);
        else chk("ready_return_cycle", 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic do_op(input logic [8:0] op, input logic sgn, input logic immv,
                         input logic [31:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        int r;
        issue(op, sgn, immv, imm, rs1, rs2, rd, r);
        wait_ready(r);
    endtask

    initial begin
        #200000;
        n_miss++;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1);
    end

    initial begin
        logic [31:0] saved;
        int          g;
        int          r;
        logic [8:0]  op;
        int          k;

        rst_n = 1'b0;
        bk_we = 1'b0;
        bk_addr = 5'd0;
        bk_data = 32'd0;
        rif.req_valid = 1'b0;
        rif.req_op = 9'd0;
        rif.req_sign = 1'b0;
        rif.req_imm_valid = 1'b0;
        rif.req_imm = 32'd0;
        rif.req_rs1 = 5'd0;
        rif.req_rs2 = 5'd0;
        rif.req_rd = 5'd0;

        #12;
        chk("rst_ready", 32'(rif.req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", 32'({done, err}), 32'd0);
        chk("rst_strobes", 32'({rf_rd_en, rf_wr_en}), 32'd0);
        chk("rst_alu_en", 32'(alu_op_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 1; i < 32; i++) set_reg(5'(i), $urandom());
        set_reg(5'd0, 32'hDEAD_BEEF);

        // add x3,x1,x2
        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd7);
        do_op(9'h001, 1'b0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3);
        // xori x4,x1,0xF0
        set_reg(5'd1, 32'h0000_00FF);
        do_op(9'h010, 1'b0, 1'b1, 32'h0000_00F0, 5'd1, 5'd0, 5'd4);
        // slt / sltu x5,x1,x2
        set_reg(5'd1, 32'hFFFF_FFFE);
        set_reg(5'd2, 32'd1);
        do_op(9'h008, 1'b1, 1'b0, 32'd0, 5'd1, 5'd2, 5'd5);
        do_op(9'h008, 1'b0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd5);
        // illegal encodings back to back, each accepted in the previous err cycle
        do_op(9'h003, 1'b0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd6);
        do_op(9'h000, 1'b0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd6);
        do_op(9'h002, 1'b0, 1'b1, 32'd9, 5'd1, 5'd2, 5'd6);
        // x0 destination, x0 sources, rs1==rs2
        do_op(9'h001, 1'b0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd0);
        do_op(9'h001, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd6);
        do_op(9'h080, 1'b0, 1'b0, 32'd0, 5'd0, 5'd2, 5'd7);
        do_op(9'h002, 1'b0, 1'b0, 32'd0, 5'd1, 5'd1, 5'd8);

        // reset during EXEC drops the op
        saved = ref_rf[3];
        issue(9'h001, 1'b0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3, r);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (alu_op_en == 9'd0 && g < 20);
        chk("reach_exec", 32'(alu_op_en != 9'd0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_alu", 32'(alu_op_en) | alu_in1 | alu_in2, 32'd0);
        chk("rst_exec_wb", 32'({rf_wr_en, done}), 32'd0);
        chk("rst_exec_ready", 32'({rif.req_ready, busy}), 32'd2);
        exp_q.delete();
        ref_rf[3] = saved;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(9'h001, 1'b0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            if (k == 9) op = 9'($urandom());
            else op = 9'b1 << k;
            do_op(op, 1'($urandom()), 1'($urandom()), $urandom(),
                  5'($urandom()), 5'($urandom()), 5'($urandom()));
        end

        repeat (8) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
